// File: rtl/async_mmap_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// async_mmap_read_arbiter_pkg
//   Shared defaults and helpers for the async_mmap read arbiter slice.
//   - Default address/data widths and port/outstanding counts.
//   - port_id_width(): width of a requester ID, clog2(num_ports), minimum 1.
//   - rr_wrap_inc() / rr_wrap_add(): modulo-NumPorts pointer arithmetic that
//     also works when NumPorts is not a power of two.
// -----------------------------------------------------------------------------
package async_mmap_read_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT      = 64;
    localparam int unsigned DATA_WIDTH_DEFAULT      = 512;
    localparam int unsigned NUM_PORTS_DEFAULT       = 4;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 64;
    localparam int unsigned MAX_OUTSTANDING_LOG_DEF = 6;

    function automatic int unsigned port_id_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    // Next index after idx, wrapping num-1 -> 0.
    function automatic int rr_wrap_inc(input int idx, input int num);
        return (idx >= num - 1) ? 0 : idx + 1;
    endfunction

    // (base + offset) mod num, for base < num and offset < num.
    function automatic int rr_wrap_add(input int base, input int offset, input int num);
        int sum;
        sum = base + offset;
        return (sum >= num) ? sum - num : sum;
    endfunction

endpackage

// File: rtl/async_mmap_read_arbiter_rr.sv
// -----------------------------------------------------------------------------
// async_mmap_read_arbiter_rr
//   Round-robin arbiter. Scans req_i starting at rr_ptr and grants the first
//   requesting port when en_i is high. The pointer moves to one past the
//   granted port; with no grant it holds.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i              per-port request vector
//   en_i               grant permitted this cycle
//   grant_valid_o      a port is granted this cycle
//   grant_onehot_o     one-hot grant (all zero when no grant)
//   grant_idx_o        encoded grant index
// -----------------------------------------------------------------------------
module async_mmap_read_arbiter_rr
    import async_mmap_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned PORT_ID_WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_PORTS-1:0]     req_i,
    input  logic                     en_i,
    output logic                     grant_valid_o,
    output logic [NUM_PORTS-1:0]     grant_onehot_o,
    output logic [PORT_ID_WIDTH-1:0] grant_idx_o
);

    logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                     found;
    int                       pos;

    always_comb begin
        found          = 1'b0;
        pos            = 0;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            pos = rr_wrap_add(int'(rr_ptr_q), k, int'(NUM_PORTS));
            if (en_i && !found && req_i[PORT_ID_WIDTH'(pos)]) begin
                found                                = 1'b1;
                grant_idx_o                          = PORT_ID_WIDTH'(pos);
                grant_onehot_o[PORT_ID_WIDTH'(pos)]  = 1'b1;
            end
        end
        grant_valid_o = found;
        rr_ptr_d      = found
                        ? PORT_ID_WIDTH'(rr_wrap_inc(int'(grant_idx_o), int'(NUM_PORTS)))
                        : rr_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
//   Show-ahead FIFO with the fifo-style handshake used across the codebase.
//   dout_o always presents the head entry while empty_n_o is high.
//   A write while full and a read while empty are silently ignored.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   din_i, write_i    push data / strobe
//   full_n_o          high when a push will be accepted
//   dout_o, read_i    head data / pop strobe
//   empty_n_o         high when dout_o is valid
// -----------------------------------------------------------------------------
module fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  write_i,
    output logic                  full_n_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    input  logic                  read_i,
    output logic                  empty_n_o
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_write;
    logic                  do_read;

    assign full_n_o  = (count_q != DEPTH_CNT);
    assign empty_n_o = (count_q != '0);
    assign dout_o    = mem_q[rd_ptr_q];

    assign do_write = write_i && full_n_o;
    assign do_read  = read_i && empty_n_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (do_read) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/async_mmap_read_arbiter.sv
// -----------------------------------------------------------------------------
// async_mmap_read_arbiter
//   Shares the read side of one async_mmap between NumPorts requesters.
//   Each port's addresses go through a 2-entry buffer; a round-robin arbiter
//   issues one address per cycle to read_addr while both async_mmap and the
//   tag FIFO have room. The granted port ID is queued in the tag FIFO, and
//   since read data returns in issue order the tag head names the port that
//   owns the current read_data beat. A stalled head port blocks all others.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_addr_din/write/full_n    per-port address push interface (flattened)
//   resp_data_dout/read/empty_n  per-port data pop interface (all lanes carry
//                                read_data_dout; only the head port's empty_n
//                                is raised)
//   read_addr_din/write/full_n   push side of async_mmap read_addr
//   read_data_dout/read/empty_n  pop side of async_mmap read_data
//   async_mmap must share rst so no data returns for discarded tags.
// -----------------------------------------------------------------------------
module async_mmap_read_arbiter
    import async_mmap_read_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts          = NUM_PORTS_DEFAULT,
    parameter int unsigned PortIdWidth       = port_id_width(NumPorts),
    parameter int unsigned AddrWidth         = ADDR_WIDTH_DEFAULT,
    parameter int unsigned DataWidth         = DATA_WIDTH_DEFAULT,
    parameter int unsigned MaxOutstanding    = MAX_OUTSTANDING_DEFAULT,
    parameter int unsigned MaxOutstandingLog = MAX_OUTSTANDING_LOG_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts*AddrWidth-1:0] req_addr_din,
    input  logic [NumPorts-1:0]           req_addr_write,
    output logic [NumPorts-1:0]           req_addr_full_n,
    output logic [NumPorts*DataWidth-1:0] resp_data_dout,
    input  logic [NumPorts-1:0]           resp_data_read,
    output logic [NumPorts-1:0]           resp_data_empty_n,
    output logic [AddrWidth-1:0]          read_addr_din,
    output logic                          read_addr_write,
    input  logic                          read_addr_full_n,
    input  logic [DataWidth-1:0]          read_data_dout,
    output logic                          read_data_read,
    input  logic                          read_data_empty_n
);

    logic [AddrWidth-1:0]   buf_dout [NumPorts];
    logic [NumPorts-1:0]    buf_empty_n;
    logic [NumPorts-1:0]    buf_read;

    logic                   can_issue;
    logic                   grant_valid;
    logic [NumPorts-1:0]    grant_onehot;
    logic [PortIdWidth-1:0] grant_idx;

    logic                   tag_full_n;
    logic                   tag_empty_n;
    logic                   tag_read;
    logic [PortIdWidth-1:0] tag_head;

    for (genvar i = 0; i < int'(NumPorts); i++) begin : g_port
        fifo #(
            .DATA_WIDTH (AddrWidth),
            .ADDR_WIDTH (1),
            .DEPTH      (2)
        ) u_addr_buf (
            .clk_i     (clk),
            .rst_i     (rst),
            .din_i     (req_addr_din[i*AddrWidth +: AddrWidth]),
            .write_i   (req_addr_write[i]),
            .full_n_o  (req_addr_full_n[i]),
            .dout_o    (buf_dout[i]),
            .read_i    (buf_read[i]),
            .empty_n_o (buf_empty_n[i])
        );

        assign resp_data_dout[i*DataWidth +: DataWidth] = read_data_dout;
        assign resp_data_empty_n[i] = read_data_empty_n && tag_empty_n
                                      && (tag_head == PortIdWidth'(i));
    end

    // Issue only when both async_mmap and the tag FIFO can take an entry, so
    // every issued address is guaranteed a tag.
    assign can_issue = read_addr_full_n && tag_full_n;

    async_mmap_read_arbiter_rr #(
        .NUM_PORTS     (NumPorts),
        .PORT_ID_WIDTH (PortIdWidth)
    ) u_rr (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (buf_empty_n),
        .en_i           (can_issue),
        .grant_valid_o  (grant_valid),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx)
    );

    assign buf_read        = grant_onehot;
    assign read_addr_write = grant_valid;
    assign read_addr_din   = buf_dout[grant_idx];

    fifo #(
        .DATA_WIDTH (PortIdWidth),
        .ADDR_WIDTH (MaxOutstandingLog),
        .DEPTH      (MaxOutstanding)
    ) u_tag_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .din_i     (grant_idx),
        .write_i   (grant_valid),
        .full_n_o  (tag_full_n),
        .dout_o    (tag_head),
        .read_i    (tag_read),
        .empty_n_o (tag_empty_n)
    );

    // A beat is consumed only when its owner (the tag head) pops it; pops on
    // any other lane are ignored. The same event retires the tag.
    assign tag_read       = read_data_empty_n && tag_empty_n && resp_data_read[tag_head];
    assign read_data_read = tag_read;

endmodule

// File: tb/tb_async_mmap_read_arbiter.sv
module tb_async_mmap_read_arbiter;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  req_addr_din;
    logic [NP-1:0]     req_addr_write;
    logic [NP-1:0]     req_addr_full_n;
    logic [NP*DW-1:0]  resp_data_dout;
    logic [NP-1:0]     resp_data_read;
    logic [NP-1:0]     resp_data_empty_n;
    logic [AW-1:0]     read_addr_din;
    logic              read_addr_write;
    logic              read_addr_full_n;
    logic [DW-1:0]     read_data_dout;
    logic              read_data_read;
    logic              read_data_empty_n;

    int n_checks = 0;
    int n_pass   = 0;

    async_mmap_read_arbiter #(
        .NumPorts          (NP),
        .PortIdWidth       (2),
        .AddrWidth         (AW),
        .DataWidth         (DW),
        .MaxOutstanding    (4),
        .MaxOutstandingLog (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_addr_din      (req_addr_din),
        .req_addr_write    (req_addr_write),
        .req_addr_full_n   (req_addr_full_n),
        .resp_data_dout    (resp_data_dout),
        .resp_data_read    (resp_data_read),
        .resp_data_empty_n (resp_data_empty_n),
        .read_addr_din     (read_addr_din),
        .read_addr_write   (read_addr_write),
        .read_addr_full_n  (read_addr_full_n),
        .read_data_dout    (read_data_dout),
        .read_data_read    (read_data_read),
        .read_data_empty_n (read_data_empty_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int port, input logic [AW-1:0] addr);
        req_addr_din[port*AW +: AW] = addr;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        req_addr_write    = '0;
        resp_data_read    = '0;
        read_data_empty_n = 1'b0;
        read_addr_full_n  = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] exp_oh;

        rst               = 1'b1;
        req_addr_din      = '0;
        req_addr_write    = '0;
        resp_data_read    = '0;
        read_addr_full_n  = 1'b1;
        read_data_dout    = '0;
        read_data_empty_n = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state: beats offered with every lane reading, but no tags.
        read_data_empty_n = 1'b1;
        resp_data_read    = 4'hF;
        #1;
        check("rst_full_n",    64'(req_addr_full_n),   64'(4'hF));
        check("rst_addr_wr",   64'(read_addr_write),   64'(0));
        check("rst_data_rd",   64'(read_data_read),    64'(0));
        check("rst_empty_n",   64'(resp_data_empty_n), 64'(0));
        read_data_empty_n = 1'b0;
        resp_data_read    = '0;

        // Single port, back-to-back pushes on port 1.
        set_addr(1, 16'h0000);
        req_addr_write = 4'b0010;
        #1;
        check("t1_no_bypass", 64'(read_addr_write), 64'(0));
        step();
        set_addr(1, 16'h0040);
        #1;
        check("t1_wr0",  64'(read_addr_write), 64'(1));
        check("t1_addr0", 64'(read_addr_din),  64'(16'h0000));
        step();
        set_addr(1, 16'h0080);
        #1;
        check("t1_addr1", 64'(read_addr_din),  64'(16'h0040));
        check("t1_full_n", 64'(req_addr_full_n), 64'(4'hF));
        step();
        req_addr_write = '0;
        #1;
        check("t1_addr2", 64'(read_addr_din),  64'(16'h0080));
        step();
        #1;
        check("t1_idle", 64'(read_addr_write), 64'(0));
        read_data_empty_n = 1'b1;
        resp_data_read    = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            read_data_dout = 32'hD000_0000 + 32'(b);
            #1;
            check("t1_lane",    64'(resp_data_empty_n),   64'(4'b0010));
            check("t1_data",    64'(resp_data_dout[DW +: DW]), 64'(32'hD000_0000 + 32'(b)));
            check("t1_pop",     64'(read_data_read),      64'(1));
            step();
        end
        #1;
        check("t1_drained",  64'(resp_data_empty_n), 64'(0));
        check("t1_no_pop",   64'(read_data_read),    64'(0));
        read_data_empty_n = 1'b0;
        resp_data_read    = '0;

        // All four ports loaded, pointer at 0: grants 0,1,2,3.
        do_reset();
        for (int p = 0; p < NP; p++) set_addr(p, 16'(16'h0100 * (p + 1)));
        req_addr_write = 4'hF;
        step();
        req_addr_write = '0;
        for (int p = 0; p < NP; p++) begin
            #1;
            check("t2_wr",    64'(read_addr_write), 64'(1));
            check("t2_grant", 64'(read_addr_din),   64'(16'(16'h0100 * (p + 1))));
            step();
        end
        #1;
        check("t2_idle", 64'(read_addr_write), 64'(0));
        read_data_empty_n = 1'b1;
        resp_data_read    = 4'hF;
        for (int p = 0; p < NP; p++) begin
            exp_oh = 4'b0001 << p;
            #1;
            check("t2_route", 64'(resp_data_empty_n), 64'(exp_oh));
            step();
        end
        read_data_empty_n = 1'b0;
        resp_data_read    = '0;
        set_addr(0, 16'h0A00);
        set_addr(2, 16'h0C00);
        req_addr_write = 4'b0101;
        step();
        req_addr_write = '0;
        #1;
        check("t2_refill0", 64'(read_addr_din), 64'(16'h0A00));
        step();
        #1;
        check("t2_refill2", 64'(read_addr_din), 64'(16'h0C00));
        step();
        #1;
        check("t2_refill_idle", 64'(read_addr_write), 64'(0));

        // Backpressure with pointer at 2, then outstanding limit of 4.
        do_reset();
        set_addr(1, 16'h0200);
        req_addr_write = 4'b0010;
        step();
        req_addr_write = '0;
        #1;
        check("t3_pre", 64'(read_addr_din), 64'(16'h0200));
        step();
        read_addr_full_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < NP; p++) set_addr(p, 16'(16'h1000 * (p + 1) + 16'h0010 * k));
            req_addr_write = 4'hF;
            #1;
            check("t3_bp_wr",     64'(read_addr_write), 64'(0));
            check("t3_bp_full_n", 64'(req_addr_full_n), 64'((k < 2) ? 4'hF : 4'h0));
            step();
        end
        req_addr_write = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t3_bp_wr", 64'(read_addr_write), 64'(0));
            step();
        end
        read_addr_full_n = 1'b1;
        #1;
        check("t3_resume2", 64'(read_addr_din), 64'(16'h3000));
        check("t3_resume_wr", 64'(read_addr_write), 64'(1));
        step();
        #1;
        check("t3_resume3", 64'(read_addr_din), 64'(16'h4000));
        step();
        #1;
        check("t3_resume0", 64'(read_addr_din), 64'(16'h1000));
        step();
        read_data_empty_n = 1'b1;
        resp_data_read    = 4'b0010;
        #1;
        check("t3_tag_full",  64'(read_addr_write),   64'(0));
        check("t3_full_n",    64'(req_addr_full_n),   64'(4'b1101));
        check("t3_head",      64'(resp_data_empty_n), 64'(4'b0010));
        check("t3_pop",       64'(read_data_read),    64'(1));
        step();
        read_data_empty_n = 1'b0;
        resp_data_read    = '0;
        #1;
        check("t3_one_more_wr", 64'(read_addr_write), 64'(1));
        check("t3_one_more",    64'(read_addr_din),   64'(16'h2000));
        step();
        #1;
        check("t3_limit", 64'(read_addr_write), 64'(0));

        // Routing and head-of-line blocking: issue order 2 then 0.
        do_reset();
        set_addr(2, 16'h0A00);
        req_addr_write = 4'b0100;
        step();
        set_addr(0, 16'h0B00);
        req_addr_write = 4'b0001;
        #1;
        check("t4_issue2", 64'(read_addr_din), 64'(16'h0A00));
        step();
        req_addr_write = '0;
        #1;
        check("t4_issue0", 64'(read_addr_din), 64'(16'h0B00));
        step();
        read_data_empty_n = 1'b1;
        read_data_dout    = 32'hCAFE_0002;
        resp_data_read    = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t4_hol_empty_n", 64'(resp_data_empty_n), 64'(4'b0100));
            check("t4_hol_no_pop",  64'(read_data_read),    64'(0));
            step();
        end
        resp_data_read = 4'b0100;
        #1;
        check("t4_pop2", 64'(read_data_read), 64'(1));
        step();
        read_data_dout = 32'hCAFE_0000;
        resp_data_read = 4'b0001;
        #1;
        check("t4_route0",  64'(resp_data_empty_n), 64'(4'b0001));
        check("t4_data0",   64'(resp_data_dout[0 +: DW]), 64'(32'hCAFE_0000));
        check("t4_pop0",    64'(read_data_read),    64'(1));
        step();
        #1;
        check("t4_drained", 64'(resp_data_empty_n), 64'(0));
        read_data_empty_n = 1'b0;
        resp_data_read    = '0;

        // Reset mid-operation: 3 tags in flight, 2 buffered addresses, ptr=3.
        do_reset();
        for (int p = 0; p < 3; p++) set_addr(p, 16'(16'h5000 + p));
        req_addr_write = 4'b0111;
        step();
        req_addr_write = '0;
        step();
        step();
        step();
        read_addr_full_n = 1'b0;
        set_addr(0, 16'h6000);
        set_addr(1, 16'h6001);
        req_addr_write = 4'b0011;
        step();
        req_addr_write    = '0;
        read_data_empty_n = 1'b1;
        #1;
        check("t5_pre_head", 64'(resp_data_empty_n), 64'(4'b0001));
        rst              = 1'b1;
        read_addr_full_n = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_empty_n", 64'(resp_data_empty_n), 64'(0));
        check("t5_addr_wr", 64'(read_addr_write),   64'(0));
        check("t5_full_n",  64'(req_addr_full_n),   64'(4'hF));
        check("t5_data_rd", 64'(read_data_read),    64'(0));
        read_data_empty_n = 1'b0;
        set_addr(2, 16'h7002);
        set_addr(3, 16'h7003);
        req_addr_write = 4'b1100;
        step();
        req_addr_write = '0;
        #1;
        check("t5_first", 64'(read_addr_din), 64'(16'h7002));
        step();
        #1;
        check("t5_second", 64'(read_addr_din), 64'(16'h7003));
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
